// File: rtl/pipe_pkg.sv
// Shared constants, helpers and stage bundle type for the elastic pipe.
// No ports; imported by pipe_stage and pipe_reg.
`ifndef PIPE_PKG_SV
`define PIPE_PKG_SV

`define PIPE_STAGE_T(W) struct packed { logic v; logic [(W)-1:0] d; }

package pipe_pkg;

    localparam int MAX_DEPTH = 16;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`endif

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: WIDTH data register plus its valid bit.
// Ports: clk, reset (async low), flush, load, in_v/in_d (source), v/d (held).
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_d,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else begin
            if (flush) begin
                v <= 1'b0;
            end else if (load) begin
                v <= in_v;
            end
            // Data moves only with a valid word; bubbles leave it stale.
            if (load && in_v) begin
                d <= in_d;
            end
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// Elastic DEPTH-stage pipeline register with valid/ready and flush.
// Ports: clk, reset (async low), in_*, out_*, flush, count (valid stages).
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("pipe_reg: DEPTH out of range 1..16");
    end

    typedef `PIPE_STAGE_T(WIDTH) stage_t;

    stage_t           st [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             acc;
    logic             in_xfer;
    logic             out_xfer;

    // Stage i may load if it is empty or some stage ahead of it frees up.
    // Built with a running OR so no net feeds back into itself.
    always_comb begin
        acc = out_ready;
        rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~st[i].v;
            rdy[i] = acc;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;

        if (i == 0) begin : g_head
            assign src_v = in_valid;
            assign src_d = in_data;
        end else begin : g_body
            assign src_v = st[i-1].v;
            assign src_d = st[i-1].d;
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .load  (rdy[i]),
            .in_v  (src_v),
            .in_d  (src_d),
            .v     (st[i].v),
            .d     (st[i].d)
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = st[DEPTH-1].v;
    assign out_data  = st[DEPTH-1].d;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// Directed self-checking bench for pipe_reg at DEPTH=2 and DEPTH=3.
// Drives inputs between edges, checks outputs 1ns after each rising edge.
module tb_pipe_reg;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, flush2;
    logic [31:0] in_data2, out_data2;
    logic [1:0]  count2;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, flush3;
    logic [31:0] in_data3, out_data3;
    logic [1:0]  count3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_reg #(.WIDTH(32), .DEPTH(2)) u2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .flush     (flush2),
        .count     (count2)
    );

    pipe_reg #(.WIDTH(32), .DEPTH(3)) u3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .flush     (flush3),
        .count     (count3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        in_valid2  = 1'b1;
        in_data2   = 32'hDEAD_BEEF;
        out_ready2 = 1'b0;
        flush2     = 1'b0;
        in_valid3  = 1'b0;
        in_data3   = '0;
        out_ready3 = 1'b0;
        flush3     = 1'b0;

        // Reset held with input activity
        for (int i = 0; i < 4; i++) begin
            in_data2 = i[0] ? ~32'hDEAD_BEEF : 32'hDEAD_BEEF;
            #1;
            chk("rst_ov", 32'(out_valid2), 32'd0);
            chk("rst_od", out_data2, 32'd0);
            chk("rst_cnt", 32'(count2), 32'd0);
            chk("rst_ir", 32'(in_ready2), 32'd1);
            tick();
        end
        in_valid2 = 1'b0;
        reset     = 1'b1;
        tick();

        // Streaming 1..4 with out_ready high
        out_ready2 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid2 = 1'b1;
            in_data2  = 32'(k);
            #1;
            chk("str_ir", 32'(in_ready2), 32'd1);
            tick();
            if (k == 1) begin
                chk("str_ov0", 32'(out_valid2), 32'd0);
                chk("str_cnt0", 32'(count2), 32'd1);
            end else begin
                chk("str_ov", 32'(out_valid2), 32'd1);
                chk("str_od", out_data2, 32'(k - 1));
                chk("str_cnt", 32'(count2), 32'd2);
            end
        end
        in_valid2 = 1'b0;
        tick();
        chk("str_od4", out_data2, 32'd4);
        chk("str_cnt4", 32'(count2), 32'd1);
        tick();
        chk("str_ovend", 32'(out_valid2), 32'd0);
        chk("str_cntend", 32'(count2), 32'd0);

        // Backpressure: A, bubble, B packs; C held
        out_ready2 = 1'b0;
        in_valid2  = 1'b1;
        in_data2   = 32'hA;
        tick();
        chk("bp_cntA", 32'(count2), 32'd1);
        in_valid2 = 1'b0;
        tick();
        chk("bp_ovA", 32'(out_valid2), 32'd1);
        chk("bp_odA", out_data2, 32'hA);
        in_valid2 = 1'b1;
        in_data2  = 32'hB;
        tick();
        chk("bp_cnt2", 32'(count2), 32'd2);
        in_data2 = 32'hC;
        #1;
        chk("bp_irfull", 32'(in_ready2), 32'd0);
        tick();
        chk("bp_hold", out_data2, 32'hA);
        chk("bp_cnthold", 32'(count2), 32'd2);
        out_ready2 = 1'b1;
        #1;
        chk("bp_irdrain", 32'(in_ready2), 32'd1);
        tick();
        chk("bp_odB", out_data2, 32'hB);
        chk("bp_cntB", 32'(count2), 32'd2);
        in_valid2 = 1'b0;
        tick();
        chk("bp_odC", out_data2, 32'hC);
        chk("bp_cntC", 32'(count2), 32'd1);
        tick();
        chk("bp_ovend", 32'(out_valid2), 32'd0);

        // Flush with head delivered in the same cycle
        out_ready2 = 1'b0;
        in_valid2  = 1'b1;
        in_data2   = 32'h7;
        tick();
        in_data2 = 32'h8;
        tick();
        chk("fl_cnt2", 32'(count2), 32'd2);
        flush2     = 1'b1;
        in_data2   = 32'h5;
        out_ready2 = 1'b1;
        #1;
        chk("fl_headv", 32'(out_valid2), 32'd1);
        chk("fl_headd", out_data2, 32'h7);
        tick();
        flush2    = 1'b0;
        in_valid2 = 1'b0;
        chk("fl_cnt0", 32'(count2), 32'd0);
        chk("fl_ov0", 32'(out_valid2), 32'd0);
        tick();
        chk("fl_no5", 32'(out_valid2), 32'd0);
        chk("fl_cntz", 32'(count2), 32'd0);

        // Async reset between edges while two words held
        out_ready2 = 1'b0;
        in_valid2  = 1'b1;
        in_data2   = 32'h11;
        tick();
        in_data2 = 32'h22;
        tick();
        chk("ar_cnt2", 32'(count2), 32'd2);
        in_valid2 = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_ov", 32'(out_valid2), 32'd0);
        chk("ar_cnt", 32'(count2), 32'd0);
        chk("ar_od", out_data2, 32'd0);
        chk("ar_ir", 32'(in_ready2), 32'd1);
        tick();
        reset      = 1'b1;
        out_ready2 = 1'b1;
        in_valid2  = 1'b1;
        in_data2   = 32'h33;
        tick();
        in_valid2 = 1'b0;
        chk("ar_lat0", 32'(out_valid2), 32'd0);
        chk("ar_cnt1", 32'(count2), 32'd1);
        tick();
        chk("ar_ov1", 32'(out_valid2), 32'd1);
        chk("ar_od1", out_data2, 32'h33);
        tick();
        chk("ar_end", 32'(count2), 32'd0);

        // DEPTH=3 full with simultaneous enqueue/dequeue
        in_valid3 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_data3 = 32'(k);
            tick();
        end
        chk("d3_cnt3", 32'(count3), 32'd3);
        in_data3 = 32'd4;
        #1;
        chk("d3_irfull", 32'(in_ready3), 32'd0);
        out_ready3 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data3 = 32'(k + 4);
            #1;
            chk("d3_ir", 32'(in_ready3), 32'd1);
            chk("d3_od", out_data3, 32'(k + 1));
            tick();
            chk("d3_cnt", 32'(count3), 32'd3);
        end
        in_valid3 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
